// File: rtl/scalar_core_pkg.sv
// Shared types and constants for the scalar core: opcodes, FSM states,
// flag bit positions and instruction field positions.
package scalar_core_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_JMP = 4'h1,
        OP_LD  = 4'h2,
        OP_ST  = 4'h3,
        OP_MOV = 4'h4,
        OP_ADD = 4'h5,
        OP_SUB = 4'h6,
        OP_LDI = 4'h7,
        OP_CFR = 4'h8,
        OP_BZ  = 4'h9,
        OP_MUL = 4'hA,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    // flags = {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;

endpackage

// File: rtl/scalar_core_alu.sv
// Combinational add/sub (and optional unsigned multiply) with Z/N/C/V flags.
// The multiplier exists only when SCALAR_CORE_MUL_EN is defined.
module scalar_core_alu
    import scalar_core_pkg::*;
#(
    parameter int DW = 16
) (
    input  opcode_e         op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   result,
    output logic [3:0]      flags
);

    logic [DW:0] sum;
    logic [DW:0] diff;
    logic        carry;
    logic        ovf;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

`ifdef SCALAR_CORE_MUL_EN
    logic [2*DW-1:0] prod;
    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
`endif

    always_comb begin
        result = sum[DW-1:0];
        carry  = sum[DW];
        ovf    = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
        case (op)
            // carry is inverted borrow so C=1 means a >= b unsigned
            OP_SUB: begin
                result = diff[DW-1:0];
                carry  = ~diff[DW];
                ovf    = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
            end
`ifdef SCALAR_CORE_MUL_EN
            OP_MUL: begin
                result = prod[DW-1:0];
                carry  = |prod[2*DW-1:DW];
                ovf    = 1'b0;
            end
`endif
            default: ;
        endcase
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[DW-1];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/scalar_core.sv
// Multi-cycle scalar core: FETCH -> EXEC [-> MEM] -> FETCH, HLT parks in HALT.
// Define SCALAR_CORE_MUL_EN to turn opcode A into an unsigned MUL.
module scalar_core
    import scalar_core_pkg::*;
#(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int NREG = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [3:0]    flags,
    output logic          halted
);

    localparam int RIW = $clog2(NREG);

    state_e           state, state_n;
    logic [AW-1:0]    pc;
    opcode_e          op_r;
    logic [RIW-1:0]   rd_r;
    logic [IMM_W-1:0] imm_r;
    logic [RIW-1:0]   rs;
    logic [DW-1:0]    regs [NREG];
    logic [3:0]       flag_r;
    logic [DW-1:0]    rd_val, rs_val, alu_res;
    logic [3:0]       alu_flags;

    // rs overlaps the upper nibble of imm8, so it is recovered from imm_r
    assign rs     = imm_r[RS_LSB-IMM_LSB +: RIW];
    assign rd_val = regs[rd_r];
    assign rs_val = regs[rs];
    assign flags  = flag_r;
    assign halted = (state == ST_HALT);

    scalar_core_alu #(.DW(DW)) u_alu (
        .op     (op_r),
        .a      (rd_val),
        .b      (rs_val),
        .result (alu_res),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack) state_n = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_r)
                    OP_LD, OP_ST: state_n = ST_MEM;
                    OP_HLT:       state_n = ST_HALT;
                    default:      state_n = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                if (op_r == OP_ST) begin
                    mem_we    = 1'b1;
                    mem_addr  = AW'(rd_val);
                    mem_wdata = rs_val;
                end else begin
                    mem_addr  = AW'(rs_val);
                end
                if (mem_ack) state_n = ST_FETCH;
            end
            default: ;
        endcase
        // reset must kill a pending request without waiting for a clock
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            op_r   <= OP_NOP;
            rd_r   <= '0;
            imm_r  <= '0;
            flag_r <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_FETCH: if (mem_ack) begin
                    op_r  <= opcode_e'(mem_rdata[OP_LSB +: 4]);
                    rd_r  <= mem_rdata[RD_LSB +: RIW];
                    imm_r <= mem_rdata[IMM_LSB +: IMM_W];
                    pc    <= pc + AW'(1);
                end
                ST_EXEC: begin
                    case (op_r)
                        OP_JMP: pc <= AW'(rs_val);
                        OP_BZ:  if (flag_r[FLAG_Z]) pc <= AW'(rs_val);
                        OP_MOV: regs[rd_r] <= rs_val;
                        OP_ADD, OP_SUB: begin
                            regs[rd_r] <= alu_res;
                            flag_r     <= alu_flags;
                        end
`ifdef SCALAR_CORE_MUL_EN
                        OP_MUL: begin
                            regs[rd_r] <= alu_res;
                            flag_r     <= alu_flags;
                        end
`endif
                        OP_LDI: regs[rd_r] <= DW'(imm_r);
                        OP_CFR: regs[rd_r] <= DW'(flag_r);
                        default: ;
                    endcase
                end
                ST_MEM: if (mem_ack && op_r == OP_LD) regs[rd_r] <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_core.sv
// Directed bench for scalar_core: ALU vector table plus hand-written
// sequences for wait states, stores, PC wrap, halt and mid-fetch reset.
module tb_scalar_core;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NREG = 4;

    localparam logic [3:0] O_NOP = 4'h0, O_JMP = 4'h1, O_LD  = 4'h2, O_ST  = 4'h3;
    localparam logic [3:0] O_MOV = 4'h4, O_ADD = 4'h5, O_SUB = 4'h6, O_LDI = 4'h7;
    localparam logic [3:0] O_CFR = 4'h8, O_BZ  = 4'h9, O_MUL = 4'hA, O_XB  = 4'hB;
    localparam logic [15:0] HLT = 16'hF000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_req, mem_we, mem_ack, halted;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    flags;

    logic [15:0] mem [0:65535];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] alog[$];
    logic [31:0] wlog[$];
    int          wd_bad = 0;
    int          we_cyc = 0;
    int          ld_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    scalar_core #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .flags     (flags),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
        if (mem_req && mem_ack) begin
            alog.push_back(32'(mem_addr));
            if (mem_we) wlog.push_back({mem_addr, mem_wdata});
        end
    end

    always @(negedge clk) begin
        if (!mem_we && mem_wdata != '0) wd_bad++;
        if (mem_we) we_cyc++;
        if (mem_req && !mem_we && mem_addr == 16'h0080) ld_cyc++;
    end

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
    } vec_t;
    vec_t vt[10];

    int abase, wbase, we0, ld0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs);
        return {op, rd, rs, 4'h0};
    endfunction

    function automatic logic [15:0] enci(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [31:0] aget(input int i);
        if (i < alog.size()) return alog[i];
        return 32'hFFFF_FFFF;
    endfunction

    // last value stored to address a since the most recent reset
    function automatic logic [31:0] wr_at(input logic [15:0] a);
        logic [31:0] r;
        r = 32'hDEAD_BEEF;
        for (int i = wbase; i < wlog.size(); i++)
            if (wlog[i][31:16] == a) r = 32'(wlog[i][15:0]);
        return r;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[16'hFFFF] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abase = alog.size();
        wbase = wlog.size();
        we0   = we_cyc;
        ld0   = ld_cyc;
        rst   = 1'b0;
    endtask

    task automatic run_prog(input string nm, input int budget);
        int c;
        do_reset();
        c = 0;
        while (!halted && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_halt"}, 32'(halted), 32'd1);
    endtask

    initial begin
        int c, bad;

        vt[0] = '{"add_ovf",   O_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
        vt[1] = '{"sub_zero",  O_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b1010};
        vt[2] = '{"add_carry", O_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
        vt[3] = '{"sub_borrow",O_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100};
        vt[4] = '{"sub_ovf",   O_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
        vt[5] = '{"add_plain", O_ADD, 16'h1234, 16'h1111, 16'h2345, 4'b0000};
        vt[6] = '{"add_negneg",O_ADD, 16'h8000, 16'h8000, 16'h0000, 4'b1011};
        vt[7] = '{"mov",       O_MOV, 16'h7FFF, 16'h0001, 16'h0001, 4'b0000};
        vt[8] = '{"op_b_nop",  O_XB,  16'h4321, 16'h0007, 16'h4321, 4'b0000};
`ifdef SCALAR_CORE_MUL_EN
        vt[9] = '{"op_a_mul",  O_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000};
`else
        vt[9] = '{"op_a_nop",  O_MUL, 16'h0003, 16'h0005, 16'h0003, 4'b0000};
`endif

        // reset state, sampled while rst is held
        #1 rst = 1'b1;
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_flags", 32'(flags), 0);
        clear_mem();
        mem[0] = HLT;
        do_reset();
        #1;
        chk("first_fetch_req", 32'(mem_req), 1);
        chk("first_fetch_addr", 32'(mem_addr), 0);

        // ALU/move table: load operands from 0x80/0x81, operate, store result to 0x90
        for (int i = 0; i < 10; i++) begin
            clear_mem();
            mem[0] = enci(O_LDI, 4'd2, 8'h80);
            mem[1] = enc(O_LD, 4'd0, 4'd2);
            mem[2] = enci(O_LDI, 4'd2, 8'h81);
            mem[3] = enc(O_LD, 4'd1, 4'd2);
            mem[4] = enc(vt[i].op, 4'd0, 4'd1);
            mem[5] = enci(O_LDI, 4'd2, 8'h90);
            mem[6] = enc(O_ST, 4'd2, 4'd0);
            mem[7] = HLT;
            mem[16'h80] = vt[i].a;
            mem[16'h81] = vt[i].b;
            run_prog(vt[i].name, 300);
            chk({vt[i].name, "_res"}, wr_at(16'h0090), 32'(vt[i].res));
            chk({vt[i].name, "_flags"}, 32'(flags), 32'(vt[i].fl));
        end

        // rd==rs doubling, then 5-5 with flags copied out through CFR
        clear_mem();
        mem[0]  = enci(O_LDI, 4'd3, 8'h21);
        mem[1]  = enc(O_ADD, 4'd3, 4'd3);
        mem[2]  = enci(O_LDI, 4'd2, 8'h92);
        mem[3]  = enc(O_ST, 4'd2, 4'd3);
        mem[4]  = enci(O_LDI, 4'd0, 8'h05);
        mem[5]  = enci(O_LDI, 4'd1, 8'h05);
        mem[6]  = enc(O_SUB, 4'd0, 4'd1);
        mem[7]  = enc(O_CFR, 4'd3, 4'd0);
        mem[8]  = enci(O_LDI, 4'd2, 8'h90);
        mem[9]  = enc(O_ST, 4'd2, 4'd0);
        mem[10] = enci(O_LDI, 4'd2, 8'h91);
        mem[11] = enc(O_ST, 4'd2, 4'd3);
        mem[12] = HLT;
        run_prog("seq_sub", 300);
        chk("self_add", wr_at(16'h0092), 32'h0042);
        chk("sub_res", wr_at(16'h0090), 32'h0000);
        chk("cfr_val", wr_at(16'h0091), 32'h000A);
        chk("sub_flags", 32'(flags), 32'hA);

        // load with three wait states on every transaction
        clear_mem();
        mem[0] = enci(O_LDI, 4'd2, 8'h80);
        mem[1] = enc(O_LD, 4'd0, 4'd2);
        mem[2] = enci(O_LDI, 4'd2, 8'h90);
        mem[3] = enc(O_ST, 4'd2, 4'd0);
        mem[4] = HLT;
        mem[16'h80] = 16'hBEEF;
        ack_delay = 3;
        run_prog("ld_wait", 400);
        ack_delay = 0;
        chk("ld_req_cycles", 32'(ld_cyc - ld0), 32'd4);
        chk("ld_txn_addr", aget(abase + 2), 32'h0080);
        chk("ld_next_fetch", aget(abase + 3), 32'h0002);
        chk("ld_value", wr_at(16'h0090), 32'hBEEF);

        // single store cycle
        clear_mem();
        mem[0] = enci(O_LDI, 4'd3, 8'h80);
        mem[1] = enc(O_LD, 4'd2, 4'd3);
        mem[2] = enci(O_LDI, 4'd1, 8'h40);
        mem[3] = enc(O_ST, 4'd1, 4'd2);
        mem[4] = HLT;
        mem[16'h80] = 16'h1234;
        run_prog("st", 300);
        chk("st_we_cycles", 32'(we_cyc - we0), 32'd1);
        chk("st_count", 32'(wlog.size() - wbase), 32'd1);
        chk("st_entry", (wlog.size() > wbase) ? wlog[wbase] : 32'hFFFF_FFFF, 32'h0040_1234);

        // PC wrap from 0xFFFF, BZ not-taken then taken, then HLT
        clear_mem();
        mem[0] = enc(O_BZ, 4'd0, 4'd2);
        mem[1] = enci(O_LDI, 4'd1, 8'h80);
        mem[2] = enc(O_LD, 4'd0, 4'd1);
        mem[3] = enci(O_LDI, 4'd2, 8'h10);
        mem[4] = enc(O_SUB, 4'd3, 4'd3);
        mem[5] = enc(O_JMP, 4'd0, 4'd0);
        mem[16'h10] = HLT;
        mem[16'h80] = 16'hFFFF;
        run_prog("wrap", 300);
        chk("wrap_bz_not_taken", aget(abase + 1), 32'h0001);
        chk("wrap_jmp_target", aget(abase + 7), 32'hFFFF);
        chk("wrap_pc_zero", aget(abase + 8), 32'h0000);
        chk("wrap_bz_taken", aget(abase + 9), 32'h0010);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req || !halted) bad++;
        end
        chk("halt_hold", 32'(bad), 0);

        // reset while a fetch is stalled
        clear_mem();
        mem[0] = enc(O_SUB, 4'd3, 4'd3);
        mem[1] = enci(O_LDI, 4'd1, 8'h11);
        do_reset();
        c = 0;
        while (!(mem_req && mem_addr == 16'h0002) && c < 50) begin
            @(negedge clk);
            c++;
        end
        ack_delay = 1000;
        repeat (3) @(negedge clk);
        chk("stall_req", 32'(mem_req), 1);
        chk("stall_addr", 32'(mem_addr), 32'h0002);
        chk("stall_flags", 32'(flags), 32'hA);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_mem_we", 32'(mem_we), 0);
        chk("arst_mem_wdata", 32'(mem_wdata), 0);
        chk("arst_halted", 32'(halted), 0);
        chk("arst_flags", 32'(flags), 0);
        ack_delay = 0;
        @(negedge clk);
        abase = alog.size();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("restart_addr", aget(abase), 32'h0000);

        chk("wdata_zero_when_read", 32'(wd_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
